war_game_ctrl: RTL and testbench
================================

Name: war_game_ctrl

Overview:
Frame-rate game sequencer for the war game display.
- Owns all dynamic object state: tank shot (ball) position and flight, enemy waypoint path, hit detection, score, shot budget, game-state FSM.
- Emits positions/enables that the pixel-level graphics block turns into rgb.
- All updates happen only on frame_tick, a one-clock pulse once per frame at pix_y==481, pix_x==0.

Parameters:
SHOTS_MAX, 9, shots per game (1..15)
SHOT_RANGE, 460, frames of flight before a shot expires
ENEMY_STEP_FRAMES, 8, frame ticks per enemy waypoint advance (1..1023)
HIT_FRAMES, 30, frame ticks hit_flash stays high

Ports:
clk in 1 system clock
reset_n in 1 asynchronous active-low reset
frame_tick in 1 one-clk pulse per frame, synchronous to clk
shoot_n in 1 fire button, active-low, raw; 2-flop synchronised internally
start in 1 start/restart request, level, sampled on frame_tick
ball_y out 9 ball top row; ball bottom = ball_y+3; ball columns fixed 316..323
ball_on out 1 ball visible/in flight
enemy_x out 10 enemy centre x
enemy_y out 9 enemy centre y
enemy_on out 1 enemy visible
hit_flash out 1 high during HIT state
score out 8 hits, saturates at 255
shots_left out 4 remaining shots
game_over out 1 high in OVER state

Behaviour:
- Reset values (async): state IDLE, ball_y=463, ball_on=0, waypoint index 0 (enemy_x=320, enemy_y=200), enemy_on=0, hit_flash=0, score=0, shots_left=SHOTS_MAX, game_over=0, all frame counters 0. A reset mid-flight or mid-HIT aborts immediately.
- Nothing changes between frame_ticks; every transition below is evaluated on the clk edge where frame_tick=1.
- FSM states:
  - IDLE: start=1 -> PLAY, enemy_on=1, score=0, shots_left=SHOTS_MAX, waypoint 0.
  - PLAY: normal play; exits defined below.
  - HIT: hit_flash=1, enemy_on=0, enemy frozen. After HIT_FRAMES ticks: waypoint reset to 0, enemy_on=1, then -> PLAY if shots_left>0, else -> OVER.
  - OVER: game_over=1, enemy_on=1 and frozen, shoot ignored. start=1 -> PLAY with the same reinit as from IDLE.
  - start is ignored in PLAY and HIT.
- Enemy path (PLAY only): step counter counts frame_ticks; at ENEMY_STEP_FRAMES the index advances and the counter clears.
  - Index wraps 7->0.
  - Waypoints (x,y): 0 (320,200), 1 (345,225), 2 (370,250), 3 (345,275), 4 (320,300), 5 (295,275), 6 (270,250), 7 (295,225).
- Fire: the synchronised shoot_n is sampled each frame_tick. Fire occurs on a 1->0 change between consecutive samples, in PLAY, with ball_on=0 and shots_left>0.
  - On fire: ball_y=463, ball_on=1, shots_left-=1, flight counter=0.
  - Holding the button fires once only. A press while in flight is discarded, not queued.
- Flight: each later frame_tick with ball_on=1: ball_y-=1 and flight counter+=1.
- Hit test uses the post-update ball_y and the current enemy centre. Hit when:
  - 316<=enemy_x+10 and enemy_x-10<=323, and
  - ball_y<=enemy_y+10 and enemy_y-10<=ball_y+3.
  - Use 11-bit unsigned compares; no wrap.
- Hit: ball_on=0, ball_y=463, score+=1 (saturating), -> HIT.
- Expire: flight counter reaches SHOT_RANGE without a hit -> ball_on=0, ball_y=463. If shots_left==0 -> OVER, else stay in PLAY.
- Hit and expire on the same tick: the hit wins.
- ball_y never goes below 463-SHOT_RANGE; it must not underflow.

Decomposition:
- Shared package war_pkg holds:
  - MAX_X=640, MAX_Y=480
  - ball column bounds 316/323, BALL_Y_T0=463, ball height 4
  - ENEMY_HALF=10
  - the 8-entry waypoint table
  - the game-state enum {IDLE, PLAY, HIT, OVER}
- One sub-module, war_enemy_path: step counter, index, table lookup. Inputs: clk, reset_n, frame_tick, advance_en, restart. Outputs: enemy_x, enemy_y.

Test Plan:
- Reset/idle: assert reset_n=0 mid-frame -> all outputs at reset values; 5 frame_ticks in IDLE, shoot_n toggled -> no change, shots_left=9.
- Straight hit (ENEMY_STEP_FRAMES=1023, enemy at 320,200):
  - start, then fire -> ball_y=463, shots_left=8.
  - 253 further ticks -> ball_y=210, hit: ball_on=0, score=1, hit_flash=1 for 30 ticks, then PLAY with enemy at (320,200).
- Miss/expire (SHOT_RANGE=100): fire -> after 100 ticks ball_on=0, ball_y=463, score=0, still PLAY; shoot_n held low throughout -> exactly one shot.
- Game over (SHOTS_MAX=1, SHOT_RANGE=100): fire, expire -> game_over=1, shots_left=0; further presses ignored; start=1 -> PLAY, score=0, shots_left=1.
- Enemy path (ENEMY_STEP_FRAMES=2): 16 ticks in PLAY -> visits the 8 waypoints in order and returns to (320,200); path frozen during HIT and OVER.
- Reset mid-flight: reset_n=0 at ball_y=300 -> ball_on=0, ball_y=463, state IDLE, score=0.

Source files
------------

// File: rtl/war_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : war_pkg
//  Description : Shared constants, waypoint table, game-state type and
//                ball/enemy overlap test for the war game sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package war_pkg;

    localparam int MAX_X      = 640;
    localparam int MAX_Y      = 480;
    localparam int X_W        = $clog2(MAX_X);
    localparam int Y_W        = $clog2(MAX_Y);

    localparam int BALL_X_L   = 316;
    localparam int BALL_X_R   = 323;
    localparam int BALL_Y_T0  = 463;
    localparam int BALL_H     = 4;
    localparam int ENEMY_HALF = 10;

    localparam int WP_COUNT   = 8;
    localparam int IDX_W      = $clog2(WP_COUNT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HIT  = 2'd2,
        OVER = 2'd3
    } game_state_t;

    function automatic logic [X_W-1:0] wp_x(input logic [IDX_W-1:0] idx);
        logic [X_W-1:0] x;
        case (idx)
            3'd0:    x = X_W'(320);
            3'd1:    x = X_W'(345);
            3'd2:    x = X_W'(370);
            3'd3:    x = X_W'(345);
            3'd4:    x = X_W'(320);
            3'd5:    x = X_W'(295);
            3'd6:    x = X_W'(270);
            default: x = X_W'(295);
        endcase
        return x;
    endfunction

    function automatic logic [Y_W-1:0] wp_y(input logic [IDX_W-1:0] idx);
        logic [Y_W-1:0] y;
        case (idx)
            3'd0:    y = Y_W'(200);
            3'd1:    y = Y_W'(225);
            3'd2:    y = Y_W'(250);
            3'd3:    y = Y_W'(275);
            3'd4:    y = Y_W'(300);
            3'd5:    y = Y_W'(275);
            3'd6:    y = Y_W'(250);
            default: y = Y_W'(225);
        endcase
        return y;
    endfunction

    // Box overlap of the ball (fixed columns, 4 rows from ball_y) against the
    // enemy square. Subtractions are moved to the other side of each compare
    // so nothing can wrap in 11-bit unsigned arithmetic.
    function automatic logic hit_test(input logic [X_W-1:0] ex,
                                      input logic [Y_W-1:0] ey,
                                      input logic [Y_W-1:0] by);
        logic [10:0] x;
        logic [10:0] y;
        logic [10:0] b;
        x = 11'(ex);
        y = 11'(ey);
        b = 11'(by);
        return (x + 11'(ENEMY_HALF) >= 11'(BALL_X_L)) &&
               (x <= 11'(BALL_X_R + ENEMY_HALF)) &&
               (b <= y + 11'(ENEMY_HALF)) &&
               (y <= b + 11'(BALL_H - 1 + ENEMY_HALF));
    endfunction

endpackage
`default_nettype wire

// File: rtl/war_game_ctrl_enemy_path.sv
`default_nettype none
// ============================================================================
//  Module      : war_enemy_path
//  Description : Enemy waypoint sequencer - frame step counter, waypoint
//                index and table lookup of the enemy centre.
//  Revision    : 1.0 - initial release
// ============================================================================
module war_enemy_path
    import war_pkg::*;
#(
    parameter int ENEMY_STEP_FRAMES = 8
)(
    input  logic           clk,
    input  logic           reset_n,
    input  logic           frame_tick,
    input  logic           advance_en,
    input  logic           restart,
    output logic [X_W-1:0] enemy_x,
    output logic [Y_W-1:0] enemy_y
);

    localparam int STEP_W = $clog2(ENEMY_STEP_FRAMES + 1);

    logic [STEP_W-1:0] r_step_cnt;
    logic [IDX_W-1:0]  r_idx;

    // Count frame ticks while advancing; step to the next waypoint when the count completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_step_cnt <= '0;
            r_idx      <= '0;
        end else if (frame_tick) begin
            if (restart) begin
                r_step_cnt <= '0;
                r_idx      <= '0;
            end else if (advance_en) begin
                if (r_step_cnt == STEP_W'(ENEMY_STEP_FRAMES - 1)) begin
                    r_step_cnt <= '0;
                    r_idx      <= r_idx + 1'b1;
                end else begin
                    r_step_cnt <= r_step_cnt + 1'b1;
                end
            end
        end
    end

    assign enemy_x = wp_x(r_idx);
    assign enemy_y = wp_y(r_idx);

endmodule
`default_nettype wire

// File: rtl/war_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : war_game_ctrl
//  Description : Frame-rate game sequencer - shot flight, hit detection,
//                score, shot budget and game-state FSM for the war game.
//  Revision    : 1.0 - initial release
// ============================================================================
module war_game_ctrl
    import war_pkg::*;
#(
    parameter int SHOTS_MAX         = 9,
    parameter int SHOT_RANGE        = 460,
    parameter int ENEMY_STEP_FRAMES = 8,
    parameter int HIT_FRAMES        = 30
)(
    input  logic           clk,
    input  logic           reset_n,
    input  logic           frame_tick,
    input  logic           shoot_n,
    input  logic           start,
    output logic [Y_W-1:0] ball_y,
    output logic           ball_on,
    output logic [X_W-1:0] enemy_x,
    output logic [Y_W-1:0] enemy_y,
    output logic           enemy_on,
    output logic           hit_flash,
    output logic [7:0]     score,
    output logic [3:0]     shots_left,
    output logic           game_over
);

    localparam int             FLIGHT_W  = $clog2(SHOT_RANGE + 1);
    localparam int             HIT_W     = $clog2(HIT_FRAMES + 1);
    localparam logic [Y_W-1:0] C_BALL_Y0 = Y_W'(BALL_Y_T0);

    game_state_t       r_state, w_state_nxt;
    logic              r_shoot_s1, r_shoot_s2, r_shoot_prev;
    logic [Y_W-1:0]    r_ball_y, w_ball_y_nxt, w_fly_y;
    logic              r_ball_on, w_ball_on_nxt;
    logic [FLIGHT_W-1:0] r_flight_cnt, w_flight_nxt, w_fly_cnt;
    logic [HIT_W-1:0]  r_hit_cnt, w_hit_nxt;
    logic [7:0]        r_score, w_score_nxt;
    logic [3:0]        r_shots_left, w_shots_nxt;
    logic              w_fire_edge, w_path_restart, w_advance_en;

    // Two-flop synchroniser for the raw fire button (idle level is high).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shoot_s1 <= 1'b1;
            r_shoot_s2 <= 1'b1;
        end else begin
            r_shoot_s1 <= shoot_n;
            r_shoot_s2 <= r_shoot_s1;
        end
    end

    // Game state and shot datapath registers; the frame-tick button sample runs in every state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_shoot_prev <= 1'b1;
            r_ball_y     <= C_BALL_Y0;
            r_ball_on    <= 1'b0;
            r_flight_cnt <= '0;
            r_hit_cnt    <= '0;
            r_score      <= '0;
            r_shots_left <= 4'(SHOTS_MAX);
        end else begin
            if (frame_tick) begin
                r_shoot_prev <= r_shoot_s2;
            end
            r_state      <= w_state_nxt;
            r_ball_y     <= w_ball_y_nxt;
            r_ball_on    <= w_ball_on_nxt;
            r_flight_cnt <= w_flight_nxt;
            r_hit_cnt    <= w_hit_nxt;
            r_score      <= w_score_nxt;
            r_shots_left <= w_shots_nxt;
        end
    end

    assign w_fire_edge = r_shoot_prev & ~r_shoot_s2;
    assign w_fly_y     = r_ball_y - 1'b1;
    assign w_fly_cnt   = r_flight_cnt + 1'b1;

    // Next-state logic: start/reinit, fire, flight with hit-before-expire priority, hit hold-off.
    always_comb begin
        w_state_nxt    = r_state;
        w_ball_y_nxt   = r_ball_y;
        w_ball_on_nxt  = r_ball_on;
        w_flight_nxt   = r_flight_cnt;
        w_hit_nxt      = r_hit_cnt;
        w_score_nxt    = r_score;
        w_shots_nxt    = r_shots_left;
        w_path_restart = 1'b0;
        if (frame_tick) begin
            case (r_state)
                IDLE, OVER: begin
                    if (start) begin
                        w_state_nxt    = PLAY;
                        w_score_nxt    = '0;
                        w_shots_nxt    = 4'(SHOTS_MAX);
                        w_ball_y_nxt   = C_BALL_Y0;
                        w_ball_on_nxt  = 1'b0;
                        w_flight_nxt   = '0;
                        w_path_restart = 1'b1;
                    end
                end
                PLAY: begin
                    if (r_ball_on) begin
                        if (hit_test(enemy_x, enemy_y, w_fly_y)) begin
                            w_ball_on_nxt = 1'b0;
                            w_ball_y_nxt  = C_BALL_Y0;
                            w_score_nxt   = (r_score == 8'hFF) ? r_score : r_score + 1'b1;
                            w_hit_nxt     = '0;
                            w_state_nxt   = HIT;
                        end else if (w_fly_cnt == FLIGHT_W'(SHOT_RANGE)) begin
                            w_ball_on_nxt = 1'b0;
                            w_ball_y_nxt  = C_BALL_Y0;
                            if (r_shots_left == '0) begin
                                w_state_nxt = OVER;
                            end
                        end else begin
                            w_ball_y_nxt = w_fly_y;
                            w_flight_nxt = w_fly_cnt;
                        end
                    end else if (w_fire_edge && (r_shots_left != '0)) begin
                        w_ball_y_nxt  = C_BALL_Y0;
                        w_ball_on_nxt = 1'b1;
                        w_shots_nxt   = r_shots_left - 1'b1;
                        w_flight_nxt  = '0;
                    end
                end
                HIT: begin
                    if (r_hit_cnt == HIT_W'(HIT_FRAMES - 1)) begin
                        w_path_restart = 1'b1;
                        w_state_nxt    = (r_shots_left != '0) ? PLAY : OVER;
                    end else begin
                        w_hit_nxt = r_hit_cnt + 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_advance_en = (r_state == PLAY);

    war_enemy_path #(
        .ENEMY_STEP_FRAMES (ENEMY_STEP_FRAMES)
    ) u_enemy_path (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .advance_en (w_advance_en),
        .restart    (w_path_restart),
        .enemy_x    (enemy_x),
        .enemy_y    (enemy_y)
    );

    assign ball_y     = r_ball_y;
    assign ball_on    = r_ball_on;
    assign score      = r_score;
    assign shots_left = r_shots_left;
    assign enemy_on   = (r_state == PLAY) || (r_state == OVER);
    assign hit_flash  = (r_state == HIT);
    assign game_over  = (r_state == OVER);

endmodule
`default_nettype wire

// File: tb/tb_war_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_war_game_ctrl
//  Description : Directed scoreboard bench for war_game_ctrl. Instance A uses a
//                stationary enemy for straight hits; instance B uses a fast
//                enemy path and short shot range for expire/game-over play.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_war_game_ctrl;

    typedef struct packed {
        logic [8:0] ball_y;
        logic       ball_on;
        logic [9:0] ex;
        logic [8:0] ey;
        logic       eon;
        logic       hf;
        logic [7:0] score;
        logic [3:0] shots;
        logic       go;
    } snap_t;

    localparam int B_STEP = 2;

    logic clk = 1'b0;
    logic frame_tick;

    logic       a_rst_n, a_shoot_n, a_start;
    logic [8:0] a_ball_y;
    logic       a_ball_on;
    logic [9:0] a_enemy_x;
    logic [8:0] a_enemy_y;
    logic       a_enemy_on, a_hit_flash, a_game_over;
    logic [7:0] a_score;
    logic [3:0] a_shots_left;

    logic       b_rst_n, b_shoot_n, b_start;
    logic [8:0] b_ball_y;
    logic       b_ball_on;
    logic [9:0] b_enemy_x;
    logic [8:0] b_enemy_y;
    logic       b_enemy_on, b_hit_flash, b_game_over;
    logic [7:0] b_score;
    logic [3:0] b_shots_left;

    int    n_checks = 0;
    int    n_errors = 0;
    snap_t q_a[$];
    snap_t q_b[$];
    snap_t e_a, e_b;
    int    pt_b;
    int    wp_tx[8] = '{320, 345, 370, 345, 320, 295, 270, 295};
    int    wp_ty[8] = '{200, 225, 250, 275, 300, 275, 250, 225};

    always #5 clk = ~clk;

    war_game_ctrl #(
        .SHOTS_MAX(2), .SHOT_RANGE(300), .ENEMY_STEP_FRAMES(1023), .HIT_FRAMES(30)
    ) u_dut_a (
        .clk(clk), .reset_n(a_rst_n), .frame_tick(frame_tick), .shoot_n(a_shoot_n),
        .start(a_start), .ball_y(a_ball_y), .ball_on(a_ball_on), .enemy_x(a_enemy_x),
        .enemy_y(a_enemy_y), .enemy_on(a_enemy_on), .hit_flash(a_hit_flash),
        .score(a_score), .shots_left(a_shots_left), .game_over(a_game_over)
    );

    war_game_ctrl #(
        .SHOTS_MAX(2), .SHOT_RANGE(100), .ENEMY_STEP_FRAMES(B_STEP), .HIT_FRAMES(30)
    ) u_dut_b (
        .clk(clk), .reset_n(b_rst_n), .frame_tick(frame_tick), .shoot_n(b_shoot_n),
        .start(b_start), .ball_y(b_ball_y), .ball_on(b_ball_on), .enemy_x(b_enemy_x),
        .enemy_y(b_enemy_y), .enemy_on(b_enemy_on), .hit_flash(b_hit_flash),
        .score(b_score), .shots_left(b_shots_left), .game_over(b_game_over)
    );

    task automatic tick();
        repeat (3) @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cmp_snap(input string tag, input snap_t got, input snap_t exp);
        chk($sformatf("%s.ball_y", tag),     16'(got.ball_y),  16'(exp.ball_y));
        chk($sformatf("%s.ball_on", tag),    16'(got.ball_on), 16'(exp.ball_on));
        chk($sformatf("%s.enemy_x", tag),    16'(got.ex),      16'(exp.ex));
        chk($sformatf("%s.enemy_y", tag),    16'(got.ey),      16'(exp.ey));
        chk($sformatf("%s.enemy_on", tag),   16'(got.eon),     16'(exp.eon));
        chk($sformatf("%s.hit_flash", tag),  16'(got.hf),      16'(exp.hf));
        chk($sformatf("%s.score", tag),      16'(got.score),   16'(exp.score));
        chk($sformatf("%s.shots_left", tag), 16'(got.shots),   16'(exp.shots));
        chk($sformatf("%s.game_over", tag),  16'(got.go),      16'(exp.go));
    endtask

    function automatic snap_t obs_a();
        snap_t s;
        s.ball_y = a_ball_y;   s.ball_on = a_ball_on; s.ex = a_enemy_x;  s.ey = a_enemy_y;
        s.eon = a_enemy_on;    s.hf = a_hit_flash;    s.score = a_score; s.shots = a_shots_left;
        s.go = a_game_over;
        return s;
    endfunction

    function automatic snap_t obs_b();
        snap_t s;
        s.ball_y = b_ball_y;   s.ball_on = b_ball_on; s.ex = b_enemy_x;  s.ey = b_enemy_y;
        s.eon = b_enemy_on;    s.hf = b_hit_flash;    s.score = b_score; s.shots = b_shots_left;
        s.go = b_game_over;
        return s;
    endfunction

    task automatic now_a(input string tag);
        q_a.push_back(e_a);
        cmp_snap(tag, obs_a(), q_a.pop_front());
    endtask

    task automatic step_a(input string tag);
        q_a.push_back(e_a);
        tick();
        cmp_snap(tag, obs_a(), q_a.pop_front());
    endtask

    task automatic now_b(input string tag);
        q_b.push_back(e_b);
        cmp_snap(tag, obs_b(), q_b.pop_front());
    endtask

    // was_play: the DUT is in PLAY before this tick, so the path steps.
    task automatic step_b(input string tag, input bit was_play, input bit restart);
        if (restart) pt_b = 0;
        else if (was_play) pt_b++;
        e_b.ex = 10'(wp_tx[(pt_b / B_STEP) % 8]);
        e_b.ey = 9'(wp_ty[(pt_b / B_STEP) % 8]);
        q_b.push_back(e_b);
        tick();
        cmp_snap(tag, obs_b(), q_b.pop_front());
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_tick = 1'b0;
        a_rst_n = 1'b0; a_shoot_n = 1'b1; a_start = 1'b0;
        b_rst_n = 1'b0; b_shoot_n = 1'b1; b_start = 1'b0;
        e_a = '{ball_y: 9'd463, ball_on: 1'b0, ex: 10'd320, ey: 9'd200, eon: 1'b0,
                hf: 1'b0, score: 8'd0, shots: 4'd2, go: 1'b0};
        repeat (2) @(negedge clk);
        now_a("a_reset");
        a_rst_n = 1'b1;

        // IDLE ignores the button
        for (int i = 0; i < 5; i++) begin
            a_shoot_n = i[0];
            step_a("a_idle");
        end

        a_shoot_n = 1'b1; a_start = 1'b1; e_a.eon = 1'b1;
        step_a("a_start");
        a_start = 1'b0;

        // first shot: straight hit on the stationary enemy at (320,200)
        a_shoot_n = 1'b0; e_a.ball_on = 1'b1; e_a.shots = 4'd1;
        step_a("a_fire1");
        a_shoot_n = 1'b1;
        for (int k = 1; k <= 253; k++) begin
            if (k < 253) e_a.ball_y = 9'(463 - k);
            else begin
                e_a.ball_y = 9'd463; e_a.ball_on = 1'b0; e_a.score = 8'd1;
                e_a.hf = 1'b1; e_a.eon = 1'b0;
            end
            step_a("a_flight1");
        end
        for (int k = 1; k <= 30; k++) begin
            if (k == 30) begin e_a.hf = 1'b0; e_a.eon = 1'b1; end
            step_a("a_hit1");
        end

        // second shot: last of the budget, hit leads to OVER
        a_shoot_n = 1'b0; e_a.ball_on = 1'b1; e_a.shots = 4'd0;
        step_a("a_fire2");
        a_shoot_n = 1'b1;
        for (int k = 1; k <= 253; k++) begin
            if (k < 253) e_a.ball_y = 9'(463 - k);
            else begin
                e_a.ball_y = 9'd463; e_a.ball_on = 1'b0; e_a.score = 8'd2;
                e_a.hf = 1'b1; e_a.eon = 1'b0;
            end
            step_a("a_flight2");
        end
        for (int k = 1; k <= 30; k++) begin
            if (k == 30) begin e_a.hf = 1'b0; e_a.eon = 1'b1; e_a.go = 1'b1; end
            step_a("a_hit2");
        end
        for (int i = 0; i < 4; i++) begin
            a_shoot_n = i[0];
            step_a("a_over");
        end

        a_shoot_n = 1'b1; a_start = 1'b1;
        e_a.go = 1'b0; e_a.score = 8'd0; e_a.shots = 4'd2;
        step_a("a_restart");
        a_start = 1'b0;

        // fly to ball_y=300 then reset asynchronously
        a_shoot_n = 1'b0; e_a.ball_on = 1'b1; e_a.shots = 4'd1;
        step_a("a_fire3");
        for (int k = 1; k <= 163; k++) begin
            e_a.ball_y = 9'(463 - k);
            step_a("a_flight3");
        end
        #2 a_rst_n = 1'b0;
        #1;
        e_a = '{ball_y: 9'd463, ball_on: 1'b0, ex: 10'd320, ey: 9'd200, eon: 1'b0,
                hf: 1'b0, score: 8'd0, shots: 4'd2, go: 1'b0};
        now_a("a_reset_mid");

        // ---------------- instance B ----------------
        @(negedge clk);
        b_rst_n = 1'b1;
        pt_b = 0;
        e_b = '{ball_y: 9'd463, ball_on: 1'b0, ex: 10'd320, ey: 9'd200, eon: 1'b0,
                hf: 1'b0, score: 8'd0, shots: 4'd2, go: 1'b0};
        now_b("b_reset");

        b_start = 1'b1; e_b.eon = 1'b1;
        step_b("b_start", 1'b0, 1'b1);
        b_start = 1'b0;
        for (int t = 0; t < 16; t++) step_b("b_path", 1'b1, 1'b0);

        // button held low through the whole flight: one shot only
        b_shoot_n = 1'b0; e_b.ball_on = 1'b1; e_b.shots = 4'd1;
        step_b("b_fire1", 1'b1, 1'b0);
        for (int k = 1; k <= 100; k++) begin
            if (k < 100) e_b.ball_y = 9'(463 - k);
            else begin e_b.ball_y = 9'd463; e_b.ball_on = 1'b0; end
            step_b("b_flight1", 1'b1, 1'b0);
        end
        for (int t = 0; t < 5; t++) step_b("b_hold", 1'b1, 1'b0);

        b_shoot_n = 1'b1;
        step_b("b_release", 1'b1, 1'b0);
        b_shoot_n = 1'b0; e_b.ball_on = 1'b1; e_b.shots = 4'd0;
        step_b("b_fire2", 1'b1, 1'b0);
        for (int k = 1; k <= 100; k++) begin
            if (k < 100) e_b.ball_y = 9'(463 - k);
            else begin e_b.ball_y = 9'd463; e_b.ball_on = 1'b0; e_b.go = 1'b1; end
            step_b("b_flight2", 1'b1, 1'b0);
        end

        // OVER: presses ignored, path frozen
        for (int i = 0; i < 6; i++) begin
            b_shoot_n = i[0];
            step_b("b_over", 1'b0, 1'b0);
        end

        b_shoot_n = 1'b1; b_start = 1'b1;
        e_b.go = 1'b0; e_b.score = 8'd0; e_b.shots = 4'd2;
        step_b("b_restart", 1'b0, 1'b1);
        b_start = 1'b0;
        step_b("b_play", 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
